mips_ctrl_alu_path: RTL and testbench
=====================================

# mips_ctrl_alu_path

Two-stage decode-and-execute slice of the 5-stage MIPS pipeline. It combines three functions: the main control decoder, the ALU-control decoder, and the 32-bit ALU. It takes the IF/ID instruction and register-file read data, and holds the ID/EX and EX/MEM pipeline registers for everything it produces. Jump is resolved combinationally in ID; the ALU result reaches the MEM-side register two clock edges after the instruction is presented.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  single clock, all registers on rising edge
- rst  in  1  asynchronous, active-low reset
- ins  in  32  instruction from IF/ID register
- rd_data1  in  32  register-file data for ins[25:21] (rs)
- rd_data2  in  32  register-file data for ins[20:16] (rt)
- jump  out  1  combinational; 1 when ins is j
- ctrl_ex  out  4  combinational decode: [3] RegDst (1 = rt), [2:1] ALUOp, [0] ALUSrc (1 = register, 0 = immediate)
- ctrl_mem  out  3  combinational decode: [2] Branch, [1] MemRead, [0] MemWrite
- ctrl_wb  out  2  combinational decode: [1] RegWrite, [0] MemtoReg (1 = ALU result, 0 = memory)
- alu_result  out  32  combinational ALU output from the ID/EX contents
- alu_zero  out  1  alu_result == 0
- exmem_result, exmem_zero, exmem_wdata (32, registered rd_data2), exmem_regdst (5), exmem_mem (3), exmem_wb (2)  out  registered EX/MEM fields

## Operation
- Main decode on ins[31:26], giving ctrl_ex / ctrl_mem / ctrl_wb / jump:
  - 000000 (R-type): 0101 / 000 / 11 / 0
  - 100011 (lw): 1000 / 010 / 10 / 0
  - 101011 (sw): 0000 / 001 / 00 / 0
  - 000100 (beq): 0011 / 100 / 00 / 0
  - 001000 (addi): 1000 / 000 / 11 / 0
  - 000010 (j): all zero / jump=1
  - any other opcode: all outputs 0 (NOP).
- Immediate is the sign extension of ins[15:0] to 32 bits.
- ID/EX register captures ctrl_ex, ctrl_mem, ctrl_wb, rd_data1, rd_data2, the sign-extended immediate, ins[20:16] (rt) and ins[15:11] (rd).
- ALU operand B is the registered rd_data2 if ALUSrc=1, otherwise the registered immediate. Operand A is always the registered rd_data1.
- ALU control takes ALUOp and immediate[5:0] (funct):
  - ALUOp 00 → add 0010; ALUOp 01 → sub 0110; ALUOp 11 → add 0010.
  - ALUOp 10 decodes funct: 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001, 101010 slt 0111, 100111 nor 1100.
  - Any other funct → 1111.
- ALU operations:
  - add/sub are modulo 2^32; overflow is ignored and no flag is raised.
  - slt is a signed compare; result is 1 if A<B, else 0.
  - Control code 1111 gives result 0.
- RegDst mux: rt if RegDst=1, else rd.
- EX/MEM register captures alu_result, alu_zero, registered rd_data2, the RegDst mux output, and the MEM and WB control bundles.

## Timing
- Decode outputs and jump are purely combinational from ins, with zero latency.
- Instruction at edge k lands in ID/EX; alu_result/alu_zero are valid after edge k. EX/MEM outputs are valid after edge k+1.
- Back-to-back instructions are accepted every cycle. There is no stall, flush, or handshake.
- rst=0 asynchronously clears every ID/EX and EX/MEM field to 0, including mid-operation, overriding any edge.
  - Consequence: during and after reset, alu_result=0 (0+0) and alu_zero=1, and all exmem_* outputs are 0.
- First clock edge after rst rises loads normally.

## Test plan
- Reset mid-stream:
  - Stimulus: pipeline loaded with non-zero values, then rst=0 between edges.
  - Required: all exmem_* read 0 immediately; alu_result=0 and alu_zero=1.
- add:
  - Stimulus: ins=0x00221820, rd_data1=5, rd_data2=7.
  - Required: ctrl_ex=0101, ctrl_mem=000, ctrl_wb=11; after edge 1, alu_result=12 and zero=0; after edge 2, exmem_result=12, exmem_regdst=3, exmem_wb=11.
- beq:
  - Stimulus: ins=0x10220003, both reads 9.
  - Required: ctrl_ex=0011, ctrl_mem=100; after edge 1, alu_result=0 and alu_zero=1; with rd_data2=8 instead, alu_result=1 and zero=0.
- lw:
  - Stimulus: ins=0x8C430008, rd_data1=100.
  - Required: ctrl_ex=1000, ctrl_mem=010, ctrl_wb=10; alu_result=108; exmem_regdst=3.
  - Same test with ins=0x8C43FFFC: alu_result=96 (negative immediate).
- R-type edge cases:
  - slt with A=0xFFFFFFFF, B=1 → 1.
  - sub with A=0x80000000, B=1 → 0x7FFFFFFF (wrap, no flag).
  - nor with A=0, B=0 → 0xFFFFFFFF.
  - funct 000000 → result 0.
- Jump and undefined opcodes:
  - ins=0x08000010 → jump=1 and all control outputs 0.
  - ins=0xFC000000 → all control outputs 0; after edge 1, alu_result equals rd_data1 plus the immediate.

Source files
------------

// File: rtl/mips_ctrl_alu_path.sv
// mips_ctrl_alu_path: main/ALU-control decode plus 32-bit ALU with ID/EX and EX/MEM registers.
// Revision 1.0
`default_nettype none

module mips_ctrl_alu_path (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic [31:0] rd_data1,
  input  logic [31:0] rd_data2,
  output logic        jump,
  output logic [3:0]  ctrl_ex,
  output logic [2:0]  ctrl_mem,
  output logic [1:0]  ctrl_wb,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic [31:0] exmem_result,
  output logic        exmem_zero,
  output logic [31:0] exmem_wdata,
  output logic [4:0]  exmem_regdst,
  output logic [2:0]  exmem_mem,
  output logic [1:0]  exmem_wb
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  logic [31:0] imm_ext;
  logic        unused_rs;

  logic [3:0]  ex_q;
  logic [2:0]  mem_q;
  logic [1:0]  wb_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] imm_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;

  logic [3:0]  alu_ctl;
  logic [31:0] alu_b;
  logic [4:0]  regdst_sel;

  // rs is consumed by the register file upstream; only its read data arrives here.
  assign unused_rs = ^ins[25:21];
  assign imm_ext   = {{16{ins[15]}}, ins[15:0]};

  always_comb begin
    jump     = 1'b0;
    ctrl_ex  = 4'b0000;
    ctrl_mem = 3'b000;
    ctrl_wb  = 2'b00;
    case (ins[31:26])
      OP_RTYPE: begin ctrl_ex = 4'b0101; ctrl_wb = 2'b11; end
      OP_LW:    begin ctrl_ex = 4'b1000; ctrl_mem = 3'b010; ctrl_wb = 2'b10; end
      OP_SW:    begin ctrl_mem = 3'b001; end
      OP_BEQ:   begin ctrl_ex = 4'b0011; ctrl_mem = 3'b100; end
      OP_ADDI:  begin ctrl_ex = 4'b1000; ctrl_wb = 2'b11; end
      OP_J:     begin jump = 1'b1; end
      default:  begin end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
    end else begin
      ex_q  <= ctrl_ex;
      mem_q <= ctrl_mem;
      wb_q  <= ctrl_wb;
      a_q   <= rd_data1;
      b_q   <= rd_data2;
      imm_q <= imm_ext;
      rt_q  <= ins[20:16];
      rd_q  <= ins[15:11];
    end
  end

  always_comb begin
    alu_ctl = ALU_NONE;
    case (ex_q[2:1])
      2'b00, 2'b11: alu_ctl = ALU_ADD;
      2'b01:        alu_ctl = ALU_SUB;
      default: begin
        case (imm_q[5:0])
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          6'b100111: alu_ctl = ALU_NOR;
          default:   alu_ctl = ALU_NONE;
        endcase
      end
    endcase
  end

  // ALUSrc=1 selects the register operand, 0 the immediate.
  assign alu_b = ex_q[0] ? b_q : imm_q;

  always_comb begin
    alu_result = 32'd0;
    case (alu_ctl)
      ALU_ADD: alu_result = a_q + alu_b;
      ALU_SUB: alu_result = a_q - alu_b;
      ALU_AND: alu_result = a_q & alu_b;
      ALU_OR:  alu_result = a_q | alu_b;
      ALU_SLT: alu_result = {31'd0, ($signed(a_q) < $signed(alu_b))};
      ALU_NOR: alu_result = ~(a_q | alu_b);
      default: alu_result = 32'd0;
    endcase
  end

  assign alu_zero   = (alu_result == 32'd0);
  assign regdst_sel = ex_q[3] ? rt_q : rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exmem_result <= '0;
      exmem_zero   <= 1'b0;
      exmem_wdata  <= '0;
      exmem_regdst <= '0;
      exmem_mem    <= '0;
      exmem_wb     <= '0;
    end else begin
      exmem_result <= alu_result;
      exmem_zero   <= alu_zero;
      exmem_wdata  <= b_q;
      exmem_regdst <= regdst_sel;
      exmem_mem    <= mem_q;
      exmem_wb     <= wb_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_ctrl_alu_path.sv
// tb_mips_ctrl_alu_path: directed pins plus randomized traffic against a behavioural model.
// Revision 1.0
`default_nettype none

module tb_mips_ctrl_alu_path;

  logic        clk;
  logic        rst;
  logic [31:0] ins, rd_data1, rd_data2;
  logic        jump;
  logic [3:0]  ctrl_ex;
  logic [2:0]  ctrl_mem;
  logic [1:0]  ctrl_wb;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] exmem_result;
  logic        exmem_zero;
  logic [31:0] exmem_wdata;
  logic [4:0]  exmem_regdst;
  logic [2:0]  exmem_mem;
  logic [1:0]  exmem_wb;

  int compared   = 0;
  int mismatched = 0;

  mips_ctrl_alu_path dut (
    .clk(clk), .rst(rst), .ins(ins), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .jump(jump), .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .exmem_result(exmem_result), .exmem_zero(exmem_zero), .exmem_wdata(exmem_wdata),
    .exmem_regdst(exmem_regdst), .exmem_mem(exmem_mem), .exmem_wb(exmem_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [31:0] wdata;
    logic [4:0]  regdst;
    logic [2:0]  mem;
    logic [1:0]  wb;
  } stage_t;

  // {jump, ctrl_ex, ctrl_mem, ctrl_wb} straight from the opcode table
  function automatic logic [9:0] dec(input logic [31:0] i);
    case (i[31:26])
      6'b000000: return 10'b0_0101_000_11;
      6'b100011: return 10'b0_1000_010_10;
      6'b101011: return 10'b0_0000_001_00;
      6'b000100: return 10'b0_0011_100_00;
      6'b001000: return 10'b0_1000_000_11;
      6'b000010: return 10'b1_0000_000_00;
      default:   return 10'b0;
    endcase
  endfunction

  function automatic stage_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    stage_t s;
    logic [9:0]  d;
    logic [31:0] imm, bop, r;
    d   = dec(i);
    imm = {{16{i[15]}}, i[15:0]};
    bop = d[5] ? b : imm;
    if (d[7:6] == 2'b10) begin
      case (i[5:0])
        6'b100000: r = a + bop;
        6'b100010: r = a - bop;
        6'b100100: r = a & bop;
        6'b100101: r = a | bop;
        6'b101010: r = ($signed(a) < $signed(bop)) ? 32'd1 : 32'd0;
        6'b100111: r = ~(a | bop);
        default:   r = 32'd0;
      endcase
    end else if (d[7:6] == 2'b01) r = a - bop;
    else r = a + bop;
    s.res    = r;
    s.zero   = (r == 32'd0);
    s.wdata  = b;
    s.regdst = d[8] ? i[20:16] : i[15:11];
    s.mem    = d[4:2];
    s.wb     = d[1:0];
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  stage_t idex_exp, exmem_exp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_exp  <= '{res: 32'd0, zero: 1'b1, wdata: 32'd0, regdst: 5'd0, mem: 3'd0, wb: 2'd0};
      exmem_exp <= '0;
    end else begin
      idex_exp  <= model(ins, rd_data1, rd_data2);
      exmem_exp <= idex_exp;
    end
  end

  always @(negedge clk) begin
    logic [9:0] d;
    d = dec(ins);
    chk("jump",         {31'd0, jump},         {31'd0, d[9]});
    chk("ctrl_ex",      {28'd0, ctrl_ex},      {28'd0, d[8:5]});
    chk("ctrl_mem",     {29'd0, ctrl_mem},     {29'd0, d[4:2]});
    chk("ctrl_wb",      {30'd0, ctrl_wb},      {30'd0, d[1:0]});
    chk("alu_result",   alu_result,            idex_exp.res);
    chk("alu_zero",     {31'd0, alu_zero},     {31'd0, idex_exp.zero});
    chk("exmem_result", exmem_result,          exmem_exp.res);
    chk("exmem_zero",   {31'd0, exmem_zero},   {31'd0, exmem_exp.zero});
    chk("exmem_wdata",  exmem_wdata,           exmem_exp.wdata);
    chk("exmem_regdst", {27'd0, exmem_regdst}, {27'd0, exmem_exp.regdst});
    chk("exmem_mem",    {29'd0, exmem_mem},    {29'd0, exmem_exp.mem});
    chk("exmem_wb",     {30'd0, exmem_wb},     {30'd0, exmem_exp.wb});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    ins = i; rd_data1 = a; rd_data2 = b;
    #1;
  endtask

  logic [5:0] ops [7]   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
  logic [5:0] functs [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000, 6'b111001};

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    ins = 32'd0; rd_data1 = 32'd0; rd_data2 = 32'd0;
    repeat (2) step();
    chk("reset alu_result", alu_result, 32'd0);
    chk("reset alu_zero", {31'd0, alu_zero}, 32'd1);
    chk("reset exmem_result", exmem_result, 32'd0);
    #2 rst = 1'b1;

    step(); drive(32'h00221820, 32'd5, 32'd7);
    chk("add ctrl_ex", {28'd0, ctrl_ex}, 32'b0101);
    chk("add ctrl_mem", {29'd0, ctrl_mem}, 32'b000);
    chk("add ctrl_wb", {30'd0, ctrl_wb}, 32'b11);
    step();
    chk("add alu_result", alu_result, 32'd12);
    chk("add alu_zero", {31'd0, alu_zero}, 32'd0);
    drive(32'h10220003, 32'd9, 32'd9);
    chk("beq ctrl_ex", {28'd0, ctrl_ex}, 32'b0011);
    chk("beq ctrl_mem", {29'd0, ctrl_mem}, 32'b100);
    step();
    chk("add exmem_result", exmem_result, 32'd12);
    chk("add exmem_regdst", {27'd0, exmem_regdst}, 32'd3);
    chk("add exmem_wb", {30'd0, exmem_wb}, 32'b11);
    chk("beq equal alu_result", alu_result, 32'd0);
    chk("beq equal alu_zero", {31'd0, alu_zero}, 32'd1);
    drive(32'h10220003, 32'd9, 32'd8);
    step();
    chk("beq ne alu_result", alu_result, 32'd1);
    chk("beq ne alu_zero", {31'd0, alu_zero}, 32'd0);

    drive(32'h8C430008, 32'd100, 32'd0);
    chk("lw ctrl_ex", {28'd0, ctrl_ex}, 32'b1000);
    chk("lw ctrl_mem", {29'd0, ctrl_mem}, 32'b010);
    chk("lw ctrl_wb", {30'd0, ctrl_wb}, 32'b10);
    step();
    chk("lw alu_result", alu_result, 32'd108);
    drive(32'h8C43FFFC, 32'd100, 32'd0);
    step();
    chk("lw neg alu_result", alu_result, 32'd96);
    chk("lw exmem_regdst", {27'd0, exmem_regdst}, 32'd3);

    drive(32'h0022182A, 32'hFFFF_FFFF, 32'd1); step();
    chk("slt signed", alu_result, 32'd1);
    drive(32'h00221822, 32'h8000_0000, 32'd1); step();
    chk("sub wrap", alu_result, 32'h7FFF_FFFF);
    drive(32'h00221827, 32'd0, 32'd0); step();
    chk("nor zero", alu_result, 32'hFFFF_FFFF);
    drive(32'h00221800, 32'd5, 32'd7); step();
    chk("funct0 result", alu_result, 32'd0);

    drive(32'h08000010, 32'd3, 32'd4);
    chk("j jump", {31'd0, jump}, 32'd1);
    chk("j ctrl", {23'd0, ctrl_ex, ctrl_mem, ctrl_wb}, 32'd0);
    drive(32'hFC000000, 32'h0000_1234, 32'd4);
    chk("undef jump", {31'd0, jump}, 32'd0);
    chk("undef ctrl", {23'd0, ctrl_ex, ctrl_mem, ctrl_wb}, 32'd0);
    step();
    chk("undef alu_result", alu_result, 32'h0000_1234);
    drive(32'h00221820, 32'd5, 32'd7);
    step();

    // Pipeline now holds non-zero values; drop reset between edges.
    #2 rst = 1'b0;
    #1;
    chk("midrst exmem_result", exmem_result, 32'd0);
    chk("midrst exmem_wdata", exmem_wdata, 32'd0);
    chk("midrst exmem_regdst", {27'd0, exmem_regdst}, 32'd0);
    chk("midrst exmem_wb", {30'd0, exmem_wb}, 32'd0);
    chk("midrst alu_result", alu_result, 32'd0);
    chk("midrst alu_zero", {31'd0, alu_zero}, 32'd1);
    step();
    #2 rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic [31:0] i;
      step();
      i = $urandom;
      i[31:26] = ops[$urandom_range(0, 6)];
      if (i[31:26] == 6'b111111) i[31:26] = 6'(($urandom_range(0, 1) != 0) ? 6'b001101 : 6'b110001);
      if (i[31:26] == 6'b000000 && $urandom_range(0, 3) != 0) i[5:0] = functs[$urandom_range(0, 7)];
      drive(i, rand_data(), rand_data());
      if (n == 250) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
